// File: rtl/telemetry_deserialize.sv
// Oversampling serial receiver for the telemetry link: start / MSB-first data / [parity] / stop.
// Optional even-parity bit is enabled by defining TELEM_RX_PARITY_EN.
module telemetry_deserialize #(
    parameter int PACKET_WIDTH = 88,
    parameter int OVERSAMPLE   = 4
) (
    input  logic                    clk,
    input  logic                    reset_clk,
    input  logic                    serial_in,
    output logic [PACKET_WIDTH-1:0] packet,
    output logic                    packet_valid,
    output logic                    framing_error,
    output logic                    parity_error,
    output logic                    busy,
    output logic [15:0]             packet_count
);

    localparam int PW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(PACKET_WIDTH);
    localparam logic [PW-1:0] PH_MID  = PW'(OVERSAMPLE / 2 - 1);
    localparam logic [PW-1:0] PH_LAST = PW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] BC_LAST = BW'(PACKET_WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef TELEM_RX_PARITY_EN
        PARITY,
`endif
        STOP,
        WAIT_IDLE
    } state_t;

    state_t                  state_q, state_d;
    logic                    sync1_q, sync2_q;
    logic [PW-1:0]           phase_q, phase_d;
    logic [BW-1:0]           bit_cnt_q, bit_cnt_d;
    logic [PACKET_WIDTH-1:0] shift_q, shift_d;
    logic [PACKET_WIDTH-1:0] packet_q, packet_d;
    logic                    valid_q, valid_d;
    logic                    ferr_q, ferr_d;
    logic [15:0]             count_q, count_d;
    logic                    s;
`ifdef TELEM_RX_PARITY_EN
    logic                    par_bit_q, par_bit_d;
    logic                    perr_q, perr_d;
`endif

    assign s = sync2_q;

    always_comb begin
        state_d   = state_q;
        phase_d   = phase_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        packet_d  = packet_q;
        valid_d   = 1'b0;
        ferr_d    = 1'b0;
        count_d   = count_q;
`ifdef TELEM_RX_PARITY_EN
        par_bit_d = par_bit_q;
        perr_d    = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (!s) begin
                    state_d = START;
                    phase_d = '0;
                end
            end
            START: begin
                // Re-check the line half a bit in; a high here was only a glitch.
                if (phase_q == PH_MID) begin
                    phase_d = '0;
                    if (!s) begin
                        state_d   = DATA;
                        bit_cnt_d = '0;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    phase_d = phase_q + PW'(1);
                end
            end
            DATA: begin
                if (phase_q == PH_LAST) begin
                    phase_d = '0;
                    shift_d = {shift_q[PACKET_WIDTH-2:0], s};
                    if (bit_cnt_q == BC_LAST) begin
                        bit_cnt_d = '0;
`ifdef TELEM_RX_PARITY_EN
                        state_d   = PARITY;
`else
                        state_d   = STOP;
`endif
                    end else begin
                        bit_cnt_d = bit_cnt_q + BW'(1);
                    end
                end else begin
                    phase_d = phase_q + PW'(1);
                end
            end
`ifdef TELEM_RX_PARITY_EN
            PARITY: begin
                if (phase_q == PH_LAST) begin
                    phase_d   = '0;
                    par_bit_d = s;
                    state_d   = STOP;
                end else begin
                    phase_d = phase_q + PW'(1);
                end
            end
`endif
            STOP: begin
                if (phase_q == PH_LAST) begin
                    phase_d = '0;
                    if (!s) begin
                        ferr_d  = 1'b1;
                        state_d = WAIT_IDLE;
`ifdef TELEM_RX_PARITY_EN
                    end else if (^{shift_q, par_bit_q}) begin
                        perr_d  = 1'b1;
                        state_d = IDLE;
`endif
                    end else begin
                        packet_d = shift_q;
                        valid_d  = 1'b1;
                        count_d  = count_q + 16'd1;
                        state_d  = IDLE;
                    end
                end else begin
                    phase_d = phase_q + PW'(1);
                end
            end
            WAIT_IDLE: begin
                // A line stuck low after a bad stop bit must not be taken as a new start.
                if (s) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset_clk) begin
        if (reset_clk) begin
            state_q   <= IDLE;
            sync1_q   <= 1'b1;
            sync2_q   <= 1'b1;
            phase_q   <= '0;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            packet_q  <= '0;
            valid_q   <= 1'b0;
            ferr_q    <= 1'b0;
            count_q   <= 16'd0;
`ifdef TELEM_RX_PARITY_EN
            par_bit_q <= 1'b0;
            perr_q    <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            sync1_q   <= serial_in;
            sync2_q   <= sync1_q;
            phase_q   <= phase_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            packet_q  <= packet_d;
            valid_q   <= valid_d;
            ferr_q    <= ferr_d;
            count_q   <= count_d;
`ifdef TELEM_RX_PARITY_EN
            par_bit_q <= par_bit_d;
            perr_q    <= perr_d;
`endif
        end
    end

    assign packet        = packet_q;
    assign packet_valid  = valid_q;
    assign framing_error = ferr_q;
    assign busy          = (state_q != IDLE);
    assign packet_count  = count_q;
`ifdef TELEM_RX_PARITY_EN
    assign parity_error  = perr_q;
`else
    assign parity_error  = 1'b0;
`endif

endmodule

// File: doc/telemetry_deserialize.md
Name: telemetry_deserialize

Overview:
Receive end of the serial telemetry link. Recovers fixed-width telemetry packets from the single-ended bit stream driven by telemetry_serialize, using an oversampling UART-style framer in one clock domain. Sits at the input of the telemetry path inside alchitry_top, ahead of the packet FIFO/USB forwarding logic. Presents each good packet as a one-cycle valid strobe with error flags and a running good-packet count.

Parameters:
PACKET_WIDTH, 88, payload bits per frame.
OVERSAMPLE, 4, clk cycles per serial bit; even, >= 4.

Ports:
clk  input  1  sample clock; bit rate = clk / OVERSAMPLE.
reset_clk  input  1  asynchronous, active-high reset.
serial_in  input  1  asynchronous serial line; idle high.
packet  output  PACKET_WIDTH  last good packet, MSB = first data bit received.
packet_valid  output  1  one-cycle strobe: packet updated.
framing_error  output  1  one-cycle strobe: stop bit sampled low.
parity_error  output  1  one-cycle strobe: parity mismatch (feature only).
busy  output  1  high in any state other than IDLE.
packet_count  output  16  count of good packets; wraps 0xFFFF->0x0000.

Behaviour:
- Frame: start bit (0), PACKET_WIDTH data bits MSB first, [even parity bit], stop bit (1). Back-to-back frames allowed: a new start bit may immediately follow the stop bit.
- serial_in passes through a 2-flop synchronizer (reset value 1); all decisions use the synchronized value s.
- Reset (asynchronous, any time including mid-frame): state=IDLE, phase=0, bit_cnt=0, shift=0, packet=0, packet_valid=0, framing_error=0, parity_error=0, busy=0, packet_count=0.
- phase: 0..OVERSAMPLE-1 counter; bit_cnt: 0..PACKET_WIDTH-1.
- IDLE: when s==0, go to START with phase=0.
- START: increment phase; at phase==OVERSAMPLE/2-1, if s==0, go to DATA with phase=0 and bit_cnt=0 (now mid-bit aligned); if s==1, treat as a glitch and return to IDLE with no flag.
- DATA: sample s when phase==OVERSAMPLE-1 (phase then wraps to 0); shift = {shift[W-2:0], s}. After the sample taken with bit_cnt==PACKET_WIDTH-1, go to PARITY (feature on) or STOP; otherwise increment bit_cnt.
- PARITY: sample at phase==OVERSAMPLE-1 into par_bit, then go to STOP.
- STOP: sample at phase==OVERSAMPLE-1.
  - s==1 and no parity fault: packet<=shift; packet_valid=1 next cycle; packet_count+1; go to IDLE.
  - s==1 with parity fault: parity_error=1; packet unchanged; go to IDLE.
  - s==0: framing_error=1; packet unchanged; go to WAIT_IDLE.
- WAIT_IDLE: stay until s==1, then go to IDLE. A low line never starts a frame from this state.
- All strobes are registered and exactly one cycle wide. packet_valid and an error strobe never assert together.
- packet holds its value between strobes.
- Latency: packet_valid rises 1 clk after the stop-bit sample point, about 2 + (frame_bits - 0.5)*OVERSAMPLE clk after the serial_in start edge.

Optional Feature:
TELEM_RX_PARITY_EN
- Defined: frame carries one even-parity bit (XOR of data bits and parity bit == 0) between data and stop; PARITY state is present; mismatch gives parity_error and the packet is dropped.
- Undefined: no PARITY state; frame goes data -> stop; parity_error is tied to 0.

Test Plan:
- Single frame, OVERSAMPLE=4, payload 88'hA50123456789ABCDEF0123 -> one packet_valid pulse, packet==88'hA50123456789ABCDEF0123, packet_count==1, busy low after the strobe.
- Three back-to-back frames (0x0, all-ones, 0xA5..23), no idle gap -> three packet_valid pulses, each holding the correct value; packet_count==3.
- Stop bit forced to 0 on a frame -> framing_error pulse; packet keeps its previous value; line held low for 40 clk then released -> no new frame starts until s has returned high.
- 1-clk low glitch on an idle line -> no strobe; state returns to IDLE; packet_count unchanged.
- reset_clk asserted at data bit 40, then a clean frame 88'h1 -> all outputs zero during reset; next packet==88'h1 with no stale bits from the aborted frame.
- With TELEM_RX_PARITY_EN, parity bit flipped on payload 88'h3 -> parity_error pulse, no packet_valid; the correct-parity retry gives packet==88'h3.
